// File: rtl/i2c_slave_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2c_slave_responder
// Purpose : I2C target that answers to one 7-bit address. It accepts master
//           writes (each byte lands on RxData with an RxValid pulse) and
//           serves master reads from TxData (latched at every byte start and
//           signalled with a ReadRequest pulse). SCL/SDA are asynchronous to
//           clock and are brought in through a 2-flop synchronizer.
// Macro   : I2C_SLAVE_GLITCH_FILTER_EN -- when defined, SCL and SDA also pass
//           a 3-sample stability filter (3 clocks extra latency, rejects
//           pulses shorter than 3 clocks). Undefined by default.
// Ports   : clock       - system clock, rising edge
//           Reset       - asynchronous, active-low reset
//           SCL         - bus clock from the master
//           SDA         - open-drain bus data; driven only to 0 or z
//           TxData      - byte returned on a master read
//           RxData      - last byte written by the master
//           RxValid     - one-clock pulse when RxData updates
//           ReadRequest - one-clock pulse when TxData is latched
//           Busy        - high while this target owns an addressed transfer
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | bus idle or not for us; waiting for START
// ADDR       | shifting in 7-bit address + R/W
// ADDR_ACK   | pulling SDA low for the address ACK bit
// WRITE_DATA | shifting in a byte from the master
// WRITE_ACK  | pulling SDA low for the data ACK bit
// READ_DATA  | shifting a TxData byte out on SDA
// READ_ACK   | SDA released, sampling master ACK/NACK
// WAIT_STOP  | transfer over (mismatch or NACK); ignore bus until STOP/START
// ----------------------------------------------------------------------------
module i2c_slave_responder #(
   parameter logic [6:0] SlaveAddress = 7'b1001000
) (
   input  logic       clock,
   input  logic       Reset,
   input  logic       SCL,
   inout  wire        SDA,
   input  logic [7:0] TxData,
   output logic [7:0] RxData,
   output logic       RxValid,
   output logic       ReadRequest,
   output logic       Busy
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ADDR       = 3'd1,
      ADDR_ACK   = 3'd2,
      WRITE_DATA = 3'd3,
      WRITE_ACK  = 3'd4,
      READ_DATA  = 3'd5,
      READ_ACK   = 3'd6,
      WAIT_STOP  = 3'd7
   } state_t;

   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       w_scl;
   logic       w_sda;
   logic       r_scl_d;
   logic       r_sda_d;
   logic       w_scl_rise;
   logic       w_scl_fall;
   logic       w_start;
   logic       w_stop;

   state_t     r_state;
   logic [6:0] r_shift;
   logic [6:0] r_tx_shift;
   logic [3:0] r_bit_cnt;
   logic       r_rw;
   logic       r_ack_phase;
   logic       r_sda_low;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_read_req;
   logic       r_busy;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], SCL};
         r_sda_sync <= {r_sda_sync[0], SDA};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [2:0] r_scl_hist;
   logic [2:0] r_sda_hist;
   logic       r_scl_filt;
   logic       r_sda_filt;

   // A filtered level moves only once three consecutive samples agree.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_scl_hist <= 3'b111;
         r_sda_hist <= 3'b111;
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
      end else begin
         r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
         if (&r_scl_hist)       r_scl_filt <= 1'b1;
         else if (~|r_scl_hist) r_scl_filt <= 1'b0;
         if (&r_sda_hist)       r_sda_filt <= 1'b1;
         else if (~|r_sda_hist) r_sda_filt <= 1'b0;
      end
   end

   assign w_scl = r_scl_filt;
   assign w_sda = r_sda_filt;
`else
   assign w_scl = r_scl_sync[1];
   assign w_sda = r_sda_sync[1];
`endif

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_d <= w_scl;
         r_sda_d <= w_sda;
      end
   end

   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   // SCL must be high on both samples so an SDA edge coincident with an SCL
   // edge is never mistaken for START/STOP.
   assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
   assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_tx_shift  <= '0;
         r_bit_cnt   <= '0;
         r_rw        <= 1'b0;
         r_ack_phase <= 1'b0;
         r_sda_low   <= 1'b0;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_read_req  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_read_req <= 1'b0;
         if (w_start) begin
            r_state     <= ADDR;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ack_phase <= 1'b0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
         end else if (w_stop) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_ack_phase <= 1'b0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_sda_low <= 1'b0;
                  r_busy    <= 1'b0;
               end
               ADDR: begin
                  if (w_scl_rise) begin
                     r_shift <= {r_shift[5:0], w_sda};
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= '0;
                        // r_shift holds the 7 address bits; w_sda is R/W.
                        if (r_shift == SlaveAddress) begin
                           r_state     <= ADDR_ACK;
                           r_rw        <= w_sda;
                           r_ack_phase <= 1'b0;
                           r_busy      <= 1'b1;
                        end else begin
                           r_state   <= WAIT_STOP;
                           r_sda_low <= 1'b0;
                           r_busy    <= 1'b0;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               ADDR_ACK, WRITE_ACK: begin
                  // First fall starts the ACK, second fall ends it.
                  if (w_scl_fall) begin
                     if (!r_ack_phase) begin
                        r_sda_low   <= 1'b1;
                        r_ack_phase <= 1'b1;
                     end else begin
                        r_ack_phase <= 1'b0;
                        r_bit_cnt   <= '0;
                        if (r_state == ADDR_ACK && r_rw) begin
                           r_state    <= READ_DATA;
                           r_tx_shift <= TxData[6:0];
                           r_read_req <= 1'b1;
                           r_sda_low  <= ~TxData[7];
                        end else begin
                           r_state   <= WRITE_DATA;
                           r_sda_low <= 1'b0;
                        end
                     end
                  end
               end
               WRITE_DATA: begin
                  if (w_scl_rise) begin
                     r_shift <= {r_shift[5:0], w_sda};
                     if (r_bit_cnt == 4'd7) begin
                        r_rx_data   <= {r_shift, w_sda};
                        r_rx_valid  <= 1'b1;
                        r_state     <= WRITE_ACK;
                        r_bit_cnt   <= '0;
                        r_ack_phase <= 1'b0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               READ_DATA: begin
                  // r_bit_cnt counts bits already clocked out by the master.
                  if (w_scl_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_state     <= READ_ACK;
                        r_sda_low   <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_ack_phase <= 1'b0;
                     end else begin
                        r_sda_low  <= ~r_tx_shift[6];
                        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                     end
                  end
               end
               READ_ACK: begin
                  if (w_scl_rise) begin
                     if (w_sda) begin
                        r_state <= WAIT_STOP;
                        r_busy  <= 1'b0;
                     end else begin
                        r_ack_phase <= 1'b1;
                     end
                  end else if (w_scl_fall && r_ack_phase) begin
                     r_state     <= READ_DATA;
                     r_ack_phase <= 1'b0;
                     r_bit_cnt   <= '0;
                     r_tx_shift  <= TxData[6:0];
                     r_read_req  <= 1'b1;
                     r_sda_low   <= ~TxData[7];
                  end
               end
               WAIT_STOP: begin
                  r_sda_low <= 1'b0;
                  r_busy    <= 1'b0;
               end
               default: begin
                  r_state   <= IDLE;
                  r_sda_low <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign SDA         = r_sda_low ? 1'b0 : 1'bz;
   assign RxData      = r_rx_data;
   assign RxValid     = r_rx_valid;
   assign ReadRequest = r_read_req;
   assign Busy        = r_busy;

endmodule
